usart_rx_param: RTL and testbench
=================================

# usart_rx_param

Parametrised asynchronous USART receiver: next generation of the current 5–9 bit receiver. It adds:
- configurable oversampling ratio, maximum character width and receive FIFO depth;
- a qualified sample-enable strobe;
- an input synchronizer;
- optional two-stop-bit checking.

It sits between the clock generator (which supplies the sample strobe) and the register/bus interface, which pops received frames and their per-frame error flags.

## Interface
- MAX_DATA_W, 9, largest supported character size (5..9)
- OSR, 16, samples per bit; even, 8..16
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, ≥2
- i_rxclk  in  1  block clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_sample_en  in  1  one-cycle sampling strobe at OSR×baud; all bit timing advances only on it
- i_rx  in  1  asynchronous rx line, idle high
- i_char_size  in  4  character size 5..MAX_DATA_W; other values treated as MAX_DATA_W
- i_upm  in  2  parity: 00 off, 01 off (reserved), 10 even, 11 odd
- i_usbs  in  1  1 = check both stop bits
- i_mpcm  in  1  multi-processor mode
- i_rd  in  1  pop FIFO head; ignored when o_valid=0
- o_data  out  MAX_DATA_W  FIFO head character, LSB-aligned, unused MSBs 0
- o_frame_error  out  1  head entry stop-bit error
- o_parity_error  out  1  head entry parity error
- o_valid  out  1  FIFO non-empty
- o_data_overrun  out  1  a completed frame was dropped because the FIFO was full
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

## Operation
- **Reset values.** On reset, all outputs are 0, the FIFO is empty, and the FSM is in IDLE. Both synchronizer flops reset to 1.
- **Synchronizer and edge detect.** i_rx passes through a two-flop synchronizer. A falling edge is a synchronized previous=1 and current=0. Edge detection runs every clock; the start of the bit count is qualified by i_sample_en.
- **Sample counter.** Counts 0..OSR-1 on i_sample_en and wraps to 0.
  - Vote samples are taken at counts OSR/2-2, OSR/2-1 and OSR/2. The bit value is their 2-of-3 majority.
  - The decision is made at count OSR/2+1, the "decision tick".
- **FSM states.** IDLE → START → DATA → PARITY (only if i_upm[1]) → STOP1 → STOP2 (only if i_usbs) → IDLE.
  - **IDLE.** A falling edge clears the counter and enters START.
  - **START.** At the decision tick, vote=1 is a false start and returns to IDLE with nothing pushed. Vote=0 latches i_char_size, i_upm, i_usbs and i_mpcm for the whole frame; config changes mid-frame have no effect.
  - **DATA.** Bits are received LSB first, and the bit counter is loaded with the latched size. At each decision tick the bit is stored at index (size − remaining) and the counter decrements. At 0, go to PARITY or STOP1.
  - **PARITY.** pe = received bit ≠ (XOR of data bits, plus 1 for odd parity).
  - **STOP1.** fe = (vote==0).
  - **STOP2.** fe |= (vote==0).
  - After the last stop-bit decision tick, the frame completes and the FSM returns to IDLE immediately. It does not wait for the end of the stop bit, so it can resync on the next start edge.
- **MPCM.** When latched i_mpcm=1, a completed frame whose bit [size-1] is 0 is discarded: no push and no overrun.
- **FIFO.** Each entry holds {fe, pe, data}. Output fields show the head combinationally from registered storage.
  - Push on frame completion; pop on i_rd & o_valid.
  - Full with push only: the frame is dropped and o_data_overrun is set.
  - Full with push and pop in the same cycle: both are accepted, count unchanged, no overrun.
  - Empty with push and pop: only the push takes effect (the pop is ignored since o_valid=0).
  - o_data_overrun clears on the next accepted pop; set-on-drop has priority over clear in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Input latency.** i_rx reaches the synchronized signal after 2 clocks.
- **Frame completion.** Completion happens on the cycle of the last stop bit's decision tick. o_valid, o_fifo_count and the head fields update on the next clock edge (1-cycle latency).
- **Pop.** i_rd sampled high at edge N makes the next entry (or o_valid=0) visible after edge N.
- **Minimum frame duration.** (1 + size + parity + stops) × OSR sample ticks, minus (OSR/2 − 2).
- **Reset mid-frame.** The partial frame is discarded. The FIFO and flags are cleared on the same edge.

## Test plan
- **Basic frame.** Send 0x5A with OSR=16, i_sample_en tied high, 8 bits, no parity, one stop bit → one entry with o_data=0x5A, fe=0, pe=0, o_fifo_count=1. o_valid rises one clock after the stop decision tick.
- **9-bit odd parity.** Send 9-bit data 0x1A5 (five 1s) with odd parity: parity bit 0 gives pe=0; parity bit 1 gives pe=1. Then send with i_usbs=1 and the second stop bit 0 → fe=1.
- **False start.** A low glitch of 3 sample ticks → FSM returns to IDLE and o_fifo_count stays 0. A glitch corrupting 1 of the 3 vote samples of a data bit → majority value stored.
- **Overrun.** With FIFO_DEPTH=4, send 5 frames with no i_rd → count=4 and o_data_overrun=1; the 5th frame is lost and the head is the 1st frame. Pop once → overrun clears. Pop and push in the same cycle while full → count stays 4 and no overrun.
- **MPCM.** With i_mpcm=1 and 9-bit frames, send 0x0F3 then 0x1F3 → only 0x1F3 is stored.
- **Reset and config change.** Assert i_rst_n=0 mid-DATA with 2 entries queued → next edge: o_valid=0, count=0, flags 0. Changing i_char_size mid-frame → the frame is still received at the latched size.

Source files
------------

// File: rtl/usart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// usart_rx_param : oversampled asynchronous receiver with majority vote,
//                  optional parity / two stop bits, MPCM filter and FIFO.
// Revision 1.0
// ---------------------------------------------------------------------------
module usart_rx_param #(
  parameter int MAX_DATA_W = 9,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_rxclk,
  input  logic                          i_rst_n,
  input  logic                          i_sample_en,
  input  logic                          i_rx,
  input  logic [3:0]                    i_char_size,
  input  logic [1:0]                    i_upm,
  input  logic                          i_usbs,
  input  logic                          i_mpcm,
  input  logic                          i_rd,
  output logic [MAX_DATA_W-1:0]         o_data,
  output logic                          o_frame_error,
  output logic                          o_parity_error,
  output logic                          o_valid,
  output logic                          o_data_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CNT_W  = $clog2(OSR);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int ENT_W  = MAX_DATA_W + 2;
  localparam logic [CNT_W-1:0] C_VOTE0 = CNT_W'(OSR/2 - 2);
  localparam logic [CNT_W-1:0] C_VOTE1 = CNT_W'(OSR/2 - 1);
  localparam logic [CNT_W-1:0] C_VOTE2 = CNT_W'(OSR/2);
  localparam logic [CNT_W-1:0] C_DEC   = CNT_W'(OSR/2 + 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            vote_q, vote_d;
  logic [3:0]            bits_left_q, bits_left_d, size_q, size_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic [1:0]            upm_q, upm_d;
  logic                  usbs_q, usbs_d, mpcm_q, mpcm_d;
  logic                  pe_q, pe_d, fe_q, fe_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]     count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic                  fall, tick_dec, vote, frame_done, msb, frame_keep;
  logic [3:0]            size_sel;
  logic [ENT_W-1:0]      entry, head;
  logic                  pop, full, push_ok, drop;

  always_comb begin
    sync1_d     = i_rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    vote_d      = vote_q;
    bits_left_d = bits_left_q;
    size_d      = size_q;
    data_d      = data_q;
    upm_d       = upm_q;
    usbs_d      = usbs_q;
    mpcm_d      = mpcm_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    frame_done  = 1'b0;
    msb         = 1'b0;

    fall     = prev_q & ~sync2_q;
    tick_dec = i_sample_en && (cnt_q == C_DEC);
    vote     = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    size_sel = ((i_char_size >= 4'd5) && (int'(i_char_size) <= MAX_DATA_W))
               ? i_char_size : 4'(MAX_DATA_W);

    if (state_q != S_IDLE && i_sample_en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == C_VOTE0) vote_d[0] = sync2_q;
      if (cnt_q == C_VOTE1) vote_d[1] = sync2_q;
      if (cnt_q == C_VOTE2) vote_d[2] = sync2_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_dec) begin
          if (vote) begin
            state_d = S_IDLE;
          end else begin
            // Frame configuration is frozen here for the rest of the character.
            size_d      = size_sel;
            bits_left_d = size_sel;
            upm_d       = i_upm;
            usbs_d      = i_usbs;
            mpcm_d      = i_mpcm;
            data_d      = '0;
            pe_d        = 1'b0;
            fe_d        = 1'b0;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick_dec) begin
          for (int i = 0; i < MAX_DATA_W; i++) begin
            if (int'(size_q - bits_left_q) == i) data_d[i] = vote;
          end
          bits_left_d = bits_left_q - 1'b1;
          if (bits_left_q == 4'd1) state_d = upm_q[1] ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (tick_dec) begin
          pe_d    = vote ^ (^data_q) ^ upm_q[0];
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick_dec) begin
          fe_d = ~vote;
          if (usbs_q) begin
            state_d = S_STOP2;
          end else begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick_dec) begin
          fe_d       = fe_q | ~vote;
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (int'(size_q) - 1 == i) msb = data_q[i];
    end
    frame_keep = frame_done && !(mpcm_q && !msb);
    entry      = {fe_d, pe_q, data_q};
  end

  // Receive FIFO: a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    pop       = i_rd && (count_q != '0);
    full      = (count_q == CNT_FW'(FIFO_DEPTH));
    push_ok   = frame_keep && (!full || pop);
    drop      = frame_keep && full && !pop;

    if (push_ok) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    if (drop)     overrun_d = 1'b1;
    else if (pop) overrun_d = 1'b0;
  end

  always_ff @(posedge i_rxclk) begin
    if (!i_rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vote_q      <= '0;
      bits_left_q <= '0;
      size_q      <= '0;
      data_q      <= '0;
      upm_q       <= '0;
      usbs_q      <= 1'b0;
      mpcm_q      <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vote_q      <= vote_d;
      bits_left_q <= bits_left_d;
      size_q      <= size_d;
      data_q      <= data_d;
      upm_q       <= upm_d;
      usbs_q      <= usbs_d;
      mpcm_q      <= mpcm_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign o_valid        = (count_q != '0);
  assign o_data         = o_valid ? head[MAX_DATA_W-1:0] : '0;
  assign o_parity_error = o_valid & head[MAX_DATA_W];
  assign o_frame_error  = o_valid & head[MAX_DATA_W+1];
  assign o_data_overrun = overrun_q;
  assign o_fifo_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_usart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usart_rx_param : bench for usart_rx_param with a frame-level model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_usart_rx_param;
  localparam int MAX_DATA_W = 9;
  localparam int OSR        = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  // Edge index (from the clock the start bit is driven) at which a frame of
  // n bits becomes visible: 2 sync clocks + 1 detect edge + frame duration.
  localparam int LAT0       = 3 - (OSR/2 - 2);

  logic                  i_rxclk = 1'b0;
  logic                  i_rst_n, i_sample_en, i_rx, i_usbs, i_mpcm, i_rd;
  logic [3:0]            i_char_size;
  logic [1:0]            i_upm;
  logic [MAX_DATA_W-1:0] o_data;
  logic                  o_frame_error, o_parity_error, o_valid, o_data_overrun;
  logic [CW-1:0]         o_fifo_count;

  usart_rx_param #(.MAX_DATA_W(MAX_DATA_W), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_rxclk(i_rxclk), .i_rst_n(i_rst_n), .i_sample_en(i_sample_en), .i_rx(i_rx),
    .i_char_size(i_char_size), .i_upm(i_upm), .i_usbs(i_usbs), .i_mpcm(i_mpcm),
    .i_rd(i_rd), .o_data(o_data), .o_frame_error(o_frame_error),
    .o_parity_error(o_parity_error), .o_valid(o_valid),
    .o_data_overrun(o_data_overrun), .o_fifo_count(o_fifo_count)
  );

  always #5 i_rxclk = ~i_rxclk;

  int n_tests = 0;
  int n_fail  = 0;
  int sen_div = 1;
  int ev_rd_at = -1, ev_glitch_at = -1, ev_cfg_at = -1;
  int first_valid, min_cnt;
  logic [10:0] exp_q[$];

  task automatic clk_step();
    @(posedge i_rxclk);
    #1;
  endtask

  task automatic do_pop();
    i_rd = 1'b1;
    clk_step();
    i_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    i_sample_en = 1'b1;
    repeat (n) clk_step();
  endtask

  // Serialises one frame onto i_rx, OSR sample ticks per bit, then one idle bit.
  task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                            input bit pbit, input bit s1, input bit use_s2, input bit s2,
                            input int stop_after);
    bit line[$];
    int t;
    line = {};
    line.push_back(1'b0);
    for (int i = 0; i < nbits; i++) line.push_back(data[i]);
    if (has_par) line.push_back(pbit);
    line.push_back(s1);
    if (use_s2) line.push_back(s2);
    first_valid = -1;
    min_cnt     = 99;
    t           = 0;
    foreach (line[k]) begin
      for (int c = 0; c < OSR * sen_div; c++) begin
        i_rx        = (t == ev_glitch_at) ? ~line[k] : line[k];
        i_rd        = (t == ev_rd_at);
        i_sample_en = ((t % sen_div) == sen_div - 1);
        if (t == ev_cfg_at) i_char_size = 4'd5;
        clk_step();
        t++;
        if (o_valid && first_valid < 0) first_valid = t;
        if (int'(o_fifo_count) < min_cnt) min_cnt = int'(o_fifo_count);
        if (stop_after >= 0 && t >= stop_after) begin
          i_rd = 1'b0;
          return;
        end
      end
    end
    i_rd = 1'b0;
    idle(OSR * sen_div);
  endtask

  function automatic logic [10:0] model(input logic [8:0] d, input int nbits, input bit has_par,
                                        input bit odd, input bit pbit, input bit s1,
                                        input bit use_s2, input bit s2);
    logic [8:0] m;
    bit pe, fe;
    m  = d & 9'((1 << nbits) - 1);
    pe = has_par && (pbit != ((($countones(m) % 2) == 1) ^ odd));
    fe = !s1 || (use_s2 && !s2);
    return {fe, pe, m};
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0; i_rx = 1'b1; i_sample_en = 1'b1; i_rd = 1'b0;
    i_char_size = 4'd8; i_upm = 2'b00; i_usbs = 1'b0; i_mpcm = 1'b0;
    repeat (3) clk_step();
    i_rst_n = 1'b1;
    clk_step();
    n_tests++;
    if ({o_valid, o_fifo_count, o_data_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_status got v=%b cnt=%0d ovr=%b, expected all 0", o_valid, o_fifo_count, o_data_overrun);
    end
    n_tests++;
    if ({o_data, o_frame_error, o_parity_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_head got d=%h fe=%b pe=%b, expected 0", o_data, o_frame_error, o_parity_error);
    end
    idle(8);
  endtask

  task automatic test_basic();
    i_char_size = 4'd8; i_upm = 2'b00; i_usbs = 1'b0;
    send_frame(9'h05A, 8, 0, 0, 1, 0, 0, -1);
    n_tests++;
    if (first_valid != LAT0 + 10 * OSR) begin
      n_fail++;
      $display("FAIL basic_latency got edge %0d, expected %0d", first_valid, LAT0 + 10 * OSR);
    end
    n_tests++;
    if ({o_valid, o_fifo_count, o_frame_error, o_parity_error, o_data} !== {1'b1, CW'(1), 2'b00, 9'h05A}) begin
      n_fail++;
      $display("FAIL basic_frame got v=%b cnt=%0d fe=%b pe=%b d=%h, expected v=1 cnt=1 fe=0 pe=0 d=05a",
               o_valid, o_fifo_count, o_frame_error, o_parity_error, o_data);
    end
    do_pop();
    n_tests++;
    if (o_valid !== 1'b0 || o_fifo_count !== '0) begin
      n_fail++;
      $display("FAIL basic_pop got v=%b cnt=%0d, expected 0 0", o_valid, o_fifo_count);
    end
  endtask

  task automatic test_parity9();
    logic [10:0] exp9 [3];
    exp9 = '{{2'b00, 9'h1A5}, {2'b01, 9'h1A5}, {2'b10, 9'h1A5}};
    i_char_size = 4'd9; i_upm = 2'b11; i_usbs = 1'b0;
    send_frame(9'h1A5, 9, 1, 0, 1, 0, 0, -1);
    send_frame(9'h1A5, 9, 1, 1, 1, 0, 0, -1);
    i_usbs = 1'b1;
    send_frame(9'h1A5, 9, 1, 0, 1, 1, 0, -1);
    i_usbs = 1'b0;
    n_tests++;
    if (o_fifo_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL par9_count got %0d, expected 3", o_fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({o_frame_error, o_parity_error, o_data} !== exp9[i]) begin
        n_fail++;
        $display("FAIL par9_entry%0d got fe=%b pe=%b d=%h, expected fe=%b pe=%b d=%h", i,
                 o_frame_error, o_parity_error, o_data, exp9[i][10], exp9[i][9], exp9[i][8:0]);
      end
      do_pop();
    end
  endtask

  task automatic test_glitch();
    i_char_size = 4'd8; i_upm = 2'b00;
    i_rx = 1'b0;
    repeat (3) clk_step();
    idle(2 * OSR);
    n_tests++;
    if (o_fifo_count !== '0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start got cnt=%0d v=%b, expected 0 0", o_fifo_count, o_valid);
    end
    ev_glitch_at = OSR * 3 + OSR/2;
    send_frame(9'h03C, 8, 0, 0, 1, 0, 0, -1);
    ev_glitch_at = OSR * 1 + OSR/2;
    send_frame(9'h03C, 8, 0, 0, 1, 0, 0, -1);
    ev_glitch_at = -1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== 9'h03C) begin
        n_fail++;
        $display("FAIL glitch_vote%0d got v=%b d=%h, expected v=1 d=03c", i, o_valid, o_data);
      end
      do_pop();
    end
  endtask

  task automatic test_overrun();
    i_char_size = 4'd8; i_upm = 2'b00; i_usbs = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(9'(17 * (i + 1)), 8, 0, 0, 1, 0, 0, -1);
    n_tests++;
    if ({o_fifo_count, o_data_overrun, o_data} !== {CW'(4), 1'b1, 9'h011}) begin
      n_fail++;
      $display("FAIL ovr_full got cnt=%0d ovr=%b d=%h, expected cnt=4 ovr=1 d=011", o_fifo_count, o_data_overrun, o_data);
    end
    do_pop();
    n_tests++;
    if ({o_fifo_count, o_data_overrun, o_data} !== {CW'(3), 1'b0, 9'h022}) begin
      n_fail++;
      $display("FAIL ovr_clear got cnt=%0d ovr=%b d=%h, expected cnt=3 ovr=0 d=022", o_fifo_count, o_data_overrun, o_data);
    end
    send_frame(9'h066, 8, 0, 0, 1, 0, 0, -1);
    ev_rd_at = LAT0 + 10 * OSR - 1;
    send_frame(9'h077, 8, 0, 0, 1, 0, 0, -1);
    ev_rd_at = -1;
    n_tests++;
    if (min_cnt != 4 || o_fifo_count !== CW'(4) || o_data_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_push_pop got min_cnt=%0d cnt=%0d ovr=%b, expected 4 4 0", min_cnt, o_fifo_count, o_data_overrun);
    end
    exp_q = {11'h033, 11'h044, 11'h066, 11'h077};
    while (exp_q.size() > 0) begin
      n_tests++;
      if ({o_valid, o_frame_error, o_parity_error, o_data} !== {1'b1, exp_q[0]}) begin
        n_fail++;
        $display("FAIL ovr_drain got v=%b d=%h, expected v=1 d=%h", o_valid, o_data, exp_q[0][8:0]);
      end
      void'(exp_q.pop_front());
      do_pop();
    end
  endtask

  task automatic test_mpcm();
    i_char_size = 4'd9; i_upm = 2'b00; i_mpcm = 1'b1;
    send_frame(9'h0F3, 9, 0, 0, 1, 0, 0, -1);
    send_frame(9'h1F3, 9, 0, 0, 1, 0, 0, -1);
    i_mpcm = 1'b0;
    n_tests++;
    if ({o_fifo_count, o_data, o_data_overrun} !== {CW'(1), 9'h1F3, 1'b0}) begin
      n_fail++;
      $display("FAIL mpcm got cnt=%0d d=%h ovr=%b, expected cnt=1 d=1f3 ovr=0", o_fifo_count, o_data, o_data_overrun);
    end
    do_pop();
  endtask

  task automatic test_reset_mid();
    i_char_size = 4'd8; i_upm = 2'b00;
    send_frame(9'h0C3, 8, 0, 0, 0, 0, 0, -1);
    send_frame(9'h081, 8, 0, 0, 1, 0, 0, -1);
    n_tests++;
    if (o_fifo_count !== CW'(2) || o_frame_error !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got cnt=%0d fe=%b, expected 2 1", o_fifo_count, o_frame_error);
    end
    send_frame(9'h0AA, 8, 0, 0, 1, 0, 0, 4 * OSR);
    i_rx = 1'b1;
    i_rst_n = 1'b0;
    clk_step();
    n_tests++;
    if ({o_valid, o_fifo_count, o_data_overrun, o_frame_error, o_parity_error, o_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid got v=%b cnt=%0d ovr=%b fe=%b pe=%b d=%h, expected all 0",
               o_valid, o_fifo_count, o_data_overrun, o_frame_error, o_parity_error, o_data);
    end
    i_rst_n = 1'b1;
    idle(3 * OSR);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after got v=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_cfg_change();
    i_char_size = 4'd8; i_upm = 2'b00;
    ev_cfg_at = 3 * OSR;
    send_frame(9'h0A7, 8, 0, 0, 1, 0, 0, -1);
    ev_cfg_at = -1;
    i_char_size = 4'd8;
    n_tests++;
    if ({o_fifo_count, o_data} !== {CW'(1), 9'h0A7}) begin
      n_fail++;
      $display("FAIL cfg_change got cnt=%0d d=%h, expected cnt=1 d=0a7", o_fifo_count, o_data);
    end
    do_pop();
  endtask

  task automatic test_random();
    logic [8:0] d;
    int nbits;
    bit odd, has_par, pbit, s1, s2, use_s2, mp;
    logic [10:0] e;
    for (int f = 0; f < 24; f++) begin
      sen_div     = $urandom_range(1, 3);
      i_char_size = 4'($urandom_range(0, 15));
      i_upm       = 2'($urandom_range(0, 3));
      i_usbs      = 1'($urandom_range(0, 1));
      i_mpcm      = ($urandom_range(0, 3) == 0);
      nbits   = (i_char_size >= 5 && i_char_size <= 9) ? int'(i_char_size) : 9;
      has_par = i_upm[1];
      odd     = i_upm[0];
      use_s2  = i_usbs;
      mp      = i_mpcm;
      d       = 9'($urandom);
      e       = model(d, nbits, has_par, odd, 1'b0, 1'b1, 1'b0, 1'b1);
      pbit    = ((($countones(e[8:0]) % 2) == 1) ^ odd) ^ ($urandom_range(0, 3) == 0);
      s1      = ($urandom_range(0, 4) != 0);
      s2      = ($urandom_range(0, 4) != 0);
      send_frame(d, nbits, has_par, pbit, s1, use_s2, s2, -1);
      e = model(d, nbits, has_par, odd, pbit, s1, use_s2, s2);
      if (!(mp && !e[nbits-1])) exp_q.push_back(e);
      if (exp_q.size() >= 3 || f == 23) begin
        while (exp_q.size() > 0) begin
          n_tests++;
          if ({o_valid, o_frame_error, o_parity_error, o_data} !== {1'b1, exp_q[0]}) begin
            n_fail++;
            $display("FAIL rand_entry%0d got v=%b fe=%b pe=%b d=%h, expected v=1 fe=%b pe=%b d=%h", f,
                     o_valid, o_frame_error, o_parity_error, o_data, exp_q[0][10], exp_q[0][9], exp_q[0][8:0]);
          end
          void'(exp_q.pop_front());
          do_pop();
        end
        n_tests++;
        if (o_valid !== 1'b0 || o_data_overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_empty%0d got v=%b ovr=%b, expected 0 0", f, o_valid, o_data_overrun);
        end
      end
    end
    sen_div = 1;
    i_mpcm  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity9();
    test_glitch();
    test_overrun();
    test_mpcm();
    test_reset_mid();
    test_cfg_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
